// File: rtl/score_pkg.sv
// rtl/score_pkg.sv - shared types and defaults for the score accumulator
package score_pkg;

    typedef enum logic [1:0] {
        PH_IDLE = 2'b00,
        PH_PLAY = 2'b01,
        PH_OVER = 2'b10
    } phase_e;

    localparam logic [1:0] HIT_MISS = 2'b00;
    localparam logic [1:0] HIT_01   = 2'b01;
    localparam logic [1:0] HIT_10   = 2'b10;
    localparam logic [1:0] HIT_11   = 2'b11;

    localparam int DEF_WIDTH      = 16;
    localparam int DEF_NUM_PLAYER = 2;
    localparam int DEF_W_01       = 32;
    localparam int DEF_W_10       = 256;
    localparam int DEF_W_11       = 512;
    localparam int DEF_COMBO_MAX  = 3;

endpackage

// File: rtl/score_lane.sv
// rtl/score_lane.sv - one player lane: combo counter, weighted multiply-add, saturation
//
// Ports:
//   clk, reset  clock / asynchronous active-high reset
//   clear_i     clear score, combo and sat (new game or restart)
//   hit_en_i    hit strobe already qualified by the PLAY phase
//   code_i      hit code, 00 = miss
//   score_o     registered score
//   score_d_o   next-state score, lets the top judge the game on the stop edge
//   combo_o     registered combo count
//   sat_o       sticky saturation flag
module score_lane
    import score_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int W_01      = DEF_W_01,
    parameter int W_10      = DEF_W_10,
    parameter int W_11      = DEF_W_11,
    parameter int COMBO_MAX = DEF_COMBO_MAX,
    parameter int CW        = $clog2(COMBO_MAX + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             hit_en_i,
    input  logic [1:0]       code_i,
    output logic [WIDTH-1:0] score_o,
    output logic [WIDTH-1:0] score_d_o,
    output logic [CW-1:0]    combo_o,
    output logic             sat_o
);

    // Wide enough that score + weight*(combo+1) can never wrap.
    localparam int SUMW = WIDTH + CW + 2;
    localparam logic [WIDTH-1:0] MAX_SCORE = {WIDTH{1'b1}};

    logic [WIDTH-1:0] score_q, score_d;
    logic [CW-1:0]    combo_q, combo_d;
    logic             sat_q, sat_d;
    logic [SUMW-1:0]  weight, inc, sum;
    logic [CW:0]      mult;

    always_comb begin
        case (code_i)
            HIT_01:  weight = SUMW'(W_01);
            HIT_10:  weight = SUMW'(W_10);
            HIT_11:  weight = SUMW'(W_11);
            default: weight = '0;
        endcase
        // Multiplier uses the combo value before this hit updates it.
        mult = {1'b0, combo_q} + (CW+1)'(1);
        inc  = weight * SUMW'(mult);
        sum  = SUMW'(score_q) + inc;
    end

    always_comb begin
        score_d = score_q;
        combo_d = combo_q;
        sat_d   = sat_q;
        if (clear_i) begin
            score_d = '0;
            combo_d = '0;
            sat_d   = 1'b0;
        end else if (hit_en_i) begin
            if (code_i == HIT_MISS) begin
                combo_d = '0;
            end else begin
                if (sum > SUMW'(MAX_SCORE)) begin
                    score_d = MAX_SCORE;
                    sat_d   = 1'b1;
                end else begin
                    score_d = sum[WIDTH-1:0];
                end
                combo_d = (combo_q == CW'(COMBO_MAX)) ? combo_q : combo_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            score_q <= '0;
            combo_q <= '0;
            sat_q   <= 1'b0;
        end else begin
            score_q <= score_d;
            combo_q <= combo_d;
            sat_q   <= sat_d;
        end
    end

    assign score_o   = score_q;
    assign score_d_o = score_d;
    assign combo_o   = combo_q;
    assign sat_o     = sat_q;

endmodule

// File: rtl/score_accumulator.sv
// rtl/score_accumulator.sv - multi-player score accumulator with game-phase FSM and high-score hold
//
// Ports:
//   clk, reset   clock / asynchronous active-high reset (clears high_score too)
//   start, stop  begin / end a game
//   hit_valid    per-lane hit strobe;  hit_code  per-lane 2-bit code (lane i at [2i+1:2i])
//   score        per-lane score bus;   combo     per-lane combo bus;  sat  per-lane sticky flag
//   high_score   best final score since reset
//   new_high     one-cycle pulse during OVER when high_score was raised
//   winner       lane with the highest score at the last game end (lowest index on ties)
//   phase        00 IDLE, 01 PLAY, 10 OVER
module score_accumulator
    import score_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int NUM_PLAYER = DEF_NUM_PLAYER,
    parameter int W_01       = DEF_W_01,
    parameter int W_10       = DEF_W_10,
    parameter int W_11       = DEF_W_11,
    parameter int COMBO_MAX  = DEF_COMBO_MAX,
    parameter int CW         = $clog2(COMBO_MAX + 1),
    parameter int WW         = $clog2(NUM_PLAYER) | 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        stop,
    input  logic [NUM_PLAYER-1:0]       hit_valid,
    input  logic [2*NUM_PLAYER-1:0]     hit_code,
    output logic [WIDTH*NUM_PLAYER-1:0] score,
    output logic [CW*NUM_PLAYER-1:0]    combo,
    output logic [NUM_PLAYER-1:0]       sat,
    output logic [WIDTH-1:0]            high_score,
    output logic                        new_high,
    output logic [WW-1:0]               winner,
    output logic [1:0]                  phase
);

    phase_e                  state_q, state_d;
    logic                    clear;
    logic                    finish;
    logic [NUM_PLAYER-1:0]   hit_en;
    logic [WIDTH-1:0]        lane_next [NUM_PLAYER];
    logic [WIDTH-1:0]        best;
    logic [WW-1:0]           best_idx;
    logic [WIDTH-1:0]        high_score_q, high_score_d;
    logic [WW-1:0]           winner_q, winner_d;
    logic                    new_high_q, new_high_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= PH_IDLE;
        else       state_q <= state_d;
    end

    // stop beats start in PLAY; OVER always lasts exactly one cycle.
    always_comb begin
        state_d = state_q;
        clear   = 1'b0;
        finish  = 1'b0;
        case (state_q)
            PH_IDLE: if (start) begin
                state_d = PH_PLAY;
                clear   = 1'b1;
            end
            PH_PLAY: if (stop) begin
                state_d = PH_OVER;
                finish  = 1'b1;
            end else if (start) begin
                clear = 1'b1;
            end
            default: state_d = PH_IDLE;
        endcase
    end

    assign hit_en = (state_q == PH_PLAY) ? hit_valid : '0;

    for (genvar g = 0; g < NUM_PLAYER; g++) begin : g_lane
        score_lane #(
            .WIDTH(WIDTH), .W_01(W_01), .W_10(W_10), .W_11(W_11),
            .COMBO_MAX(COMBO_MAX), .CW(CW)
        ) u_lane (
            .clk      (clk),
            .reset    (reset),
            .clear_i  (clear),
            .hit_en_i (hit_en[g]),
            .code_i   (hit_code[2*g +: 2]),
            .score_o  (score[WIDTH*g +: WIDTH]),
            .score_d_o(lane_next[g]),
            .combo_o  (combo[CW*g +: CW]),
            .sat_o    (sat[g])
        );
    end

    // Judge on the final (post stop-cycle) scores so winner/high_score/new_high
    // are registered in time to be seen together with phase == OVER.
    always_comb begin
        best     = '0;
        best_idx = '0;
        for (int i = 0; i < NUM_PLAYER; i++) begin
            if (lane_next[i] > best) begin
                best     = lane_next[i];
                best_idx = WW'(i);
            end
        end
    end

    always_comb begin
        high_score_d = high_score_q;
        winner_d     = winner_q;
        new_high_d   = 1'b0;
        if (finish) begin
            winner_d = best_idx;
            if (best > high_score_q) begin
                high_score_d = best;
                new_high_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            high_score_q <= '0;
            winner_q     <= '0;
            new_high_q   <= 1'b0;
        end else begin
            high_score_q <= high_score_d;
            winner_q     <= winner_d;
            new_high_q   <= new_high_d;
        end
    end

    assign high_score = high_score_q;
    assign winner     = winner_q;
    assign new_high   = new_high_q;
    assign phase      = state_q;

endmodule

// File: tb/tb_score_accumulator.sv
// tb/tb_score_accumulator.sv - scoreboard bench for score_accumulator
module tb_score_accumulator;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [1:0]  hit_valid = '0;
    logic [3:0]  hit_code = '0;
    logic [31:0] score;
    logic [3:0]  combo;
    logic [1:0]  sat;
    logic [15:0] high_score;
    logic        new_high;
    logic [0:0]  winner;
    logic [1:0]  phase;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int s0, c0, s1, c1, sat, ph, hs, nh, win;
    } exp_t;

    exp_t exp_q[$];

    score_accumulator dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .hit_valid(hit_valid), .hit_code(hit_code),
        .score(score), .combo(combo), .sat(sat),
        .high_score(high_score), .new_high(new_high),
        .winner(winner), .phase(phase)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
        end
    endtask

    task automatic chk_all(input exp_t e);
        chk("score0", int'(score[15:0]), e.s0);
        chk("combo0", int'(combo[1:0]), e.c0);
        chk("score1", int'(score[31:16]), e.s1);
        chk("combo1", int'(combo[3:2]), e.c1);
        chk("sat", int'(sat), e.sat);
        chk("phase", int'(phase), e.ph);
        chk("high_score", int'(high_score), e.hs);
        chk("new_high", int'(new_high), e.nh);
        chk("winner", int'(winner), e.win);
    endtask

    // One clock of stimulus plus the outputs expected after that edge.
    task automatic cyc(input logic st, input logic sp, input logic [1:0] hv,
                       input logic [3:0] hc, input int s0, input int c0,
                       input int s1, input int c1, input int st_sat,
                       input int ph, input int hs, input int nh, input int win);
        exp_t e;
        @(negedge clk);
        start = st; stop = sp; hit_valid = hv; hit_code = hc;
        e.s0 = s0; e.c0 = c0; e.s1 = s1; e.c1 = c1; e.sat = st_sat;
        e.ph = ph; e.hs = hs; e.nh = nh; e.win = win;
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk_all(e);
            end
        end
    end

    initial begin : stim
        exp_t z;
        int s, c, sf, sum;
        z = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
        #3;
        chk_all(z);
        @(negedge clk);
        reset = 1'b0;

        // five back-to-back 01 hits on lane 0
        cyc(1, 0, 2'b00, 4'b0000,   0, 0, 0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 2'b01, 4'b0001,  32, 1, 0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 2'b01, 4'b0001,  96, 2, 0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 2'b01, 4'b0001, 192, 3, 0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 2'b01, 4'b0001, 320, 3, 0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 2'b01, 4'b0001, 448, 3, 0, 0, 0, 1, 0, 0, 0);

        // asynchronous reset mid-PLAY clears immediately
        @(negedge clk);
        start = 0; stop = 0; hit_valid = '0; hit_code = '0;
        #2 reset = 1'b1;
        #1 chk_all(z);
        @(negedge clk);
        reset = 1'b0;

        // miss breaks the combo
        cyc(1, 0, 2'b00, 4'b0000,   0, 0, 0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 2'b01, 4'b0001,  32, 1, 0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 2'b01, 4'b0001,  96, 2, 0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 2'b01, 4'b0000,  96, 0, 0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 2'b01, 4'b0001, 128, 1, 0, 0, 0, 1, 0, 0, 0);

        // restart in PLAY, build 448 / 768, first high score
        cyc(1, 0, 2'b00, 4'b0000,   0, 0,   0, 0, 0, 1,   0, 0, 0);
        cyc(0, 0, 2'b11, 4'b1001,  32, 1, 256, 1, 0, 1,   0, 0, 0);
        cyc(0, 0, 2'b11, 4'b1001,  96, 2, 768, 2, 0, 1,   0, 0, 0);
        cyc(0, 0, 2'b01, 4'b0001, 192, 3, 768, 2, 0, 1,   0, 0, 0);
        cyc(0, 0, 2'b01, 4'b0001, 320, 3, 768, 2, 0, 1,   0, 0, 0);
        cyc(0, 0, 2'b01, 4'b0001, 448, 3, 768, 2, 0, 1,   0, 0, 0);
        cyc(0, 1, 2'b00, 4'b0000, 448, 3, 768, 2, 0, 2, 768, 1, 1);
        cyc(0, 0, 2'b00, 4'b0000, 448, 3, 768, 2, 0, 0, 768, 0, 1);
        // hits in IDLE are ignored
        cyc(0, 0, 2'b11, 4'b0101, 448, 3, 768, 2, 0, 0, 768, 0, 1);

        // lower final max (672), stop-cycle hit still counts: no new high
        cyc(1, 0, 2'b00, 4'b0000,   0, 0,  0, 0, 0, 1, 768, 0, 1);
        cyc(0, 0, 2'b01, 4'b0011, 512, 1,  0, 0, 0, 1, 768, 0, 1);
        cyc(0, 0, 2'b01, 4'b0001, 576, 2,  0, 0, 0, 1, 768, 0, 1);
        cyc(0, 0, 2'b01, 4'b0001, 672, 3,  0, 0, 0, 1, 768, 0, 1);
        cyc(0, 1, 2'b10, 4'b0100, 672, 3, 32, 1, 0, 2, 768, 0, 0);
        cyc(0, 0, 2'b00, 4'b0000, 672, 3, 32, 1, 0, 0, 768, 0, 0);

        // both lanes tie at 768: equal to high score, lowest index wins
        cyc(1, 0, 2'b00, 4'b0000,   0, 0,   0, 0, 0, 1, 768, 0, 0);
        cyc(0, 0, 2'b11, 4'b1111, 512, 1, 512, 1, 0, 1, 768, 0, 0);
        cyc(0, 0, 2'b11, 4'b0000, 512, 0, 512, 0, 0, 1, 768, 0, 0);
        cyc(0, 0, 2'b11, 4'b1010, 768, 1, 768, 1, 0, 1, 768, 0, 0);
        cyc(0, 1, 2'b00, 4'b0000, 768, 1, 768, 1, 0, 2, 768, 0, 0);
        cyc(0, 0, 2'b00, 4'b0000, 768, 1, 768, 1, 0, 0, 768, 0, 0);

        // start+stop together in PLAY: stop wins, no clear; start in OVER ignored
        cyc(1, 0, 2'b00, 4'b0000,  0, 0, 0, 0, 0, 1, 768, 0, 0);
        cyc(0, 0, 2'b01, 4'b0001, 32, 1, 0, 0, 0, 1, 768, 0, 0);
        cyc(1, 1, 2'b00, 4'b0000, 32, 1, 0, 0, 0, 2, 768, 0, 0);
        cyc(1, 0, 2'b00, 4'b0000, 32, 1, 0, 0, 0, 0, 768, 0, 0);
        cyc(0, 0, 2'b00, 4'b0000, 32, 1, 0, 0, 0, 0, 768, 0, 0);

        // lane 1 saturates on continuous 11 hits
        cyc(1, 0, 2'b00, 4'b0000, 0, 0, 0, 0, 0, 1, 768, 0, 0);
        cyc(0, 0, 2'b10, 4'b1100, 0, 0,  512, 1, 0, 1, 768, 0, 0);
        cyc(0, 0, 2'b10, 4'b1100, 0, 0, 1536, 2, 0, 1, 768, 0, 0);
        cyc(0, 0, 2'b10, 4'b1100, 0, 0, 3072, 3, 0, 1, 768, 0, 0);
        cyc(0, 0, 2'b10, 4'b1100, 0, 0, 5120, 3, 0, 1, 768, 0, 0);
        s = 5120; c = 3; sf = 0;
        for (int k = 0; k < 32; k++) begin
            sum = s + 2048;
            if (sum > 65535) begin s = 65535; sf = 1; end
            else s = sum;
            cyc(0, 0, 2'b10, 4'b1100, 0, 0, s, c, sf * 2, 1, 768, 0, 0);
        end
        cyc(0, 0, 2'b10, 4'b0000, 0, 0, 65535, 0, 2, 1, 768, 0, 0);
        cyc(0, 0, 2'b10, 4'b1100, 0, 0, 65535, 1, 2, 1, 768, 0, 0);
        cyc(0, 1, 2'b00, 4'b0000, 0, 0, 65535, 1, 2, 2, 65535, 1, 1);
        cyc(0, 0, 2'b00, 4'b0000, 0, 0, 65535, 1, 2, 0, 65535, 0, 1);

        @(negedge clk);
        start = 0; stop = 0; hit_valid = '0; hit_code = '0;
        for (int t = 0; t < 10 && exp_q.size() > 0; t++) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
